// File: rtl/cache_pkg.sv
// Shared types and address helpers for the two-way set-associative cache.
// The field extractor is generic so the cache modules keep their widths as parameters.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    function automatic int log2c(input int n);
        return $clog2(n);
    endfunction

    // Returns the bit field [lsb +: width] of a word address.
    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb,
                                               input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty/tag/data per set, with combinational lookup and
// clocked word-write, block-fill and dirty-clear ports (all at the same set index).
module cache_way
    import cache_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WORDS  = 2,
    parameter int SETS   = 2,
    parameter int TAG_W  = 3,
    localparam int WB    = log2c(WORDS),
    localparam int IB    = log2c(SETS),
    localparam int BLK_W = DATA_W * WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IB-1:0]     idx,
    input  logic [WB-1:0]     word,
    input  logic [TAG_W-1:0]  look_tag,
    output logic              hit,
    output logic [DATA_W-1:0] rd_word,
    output logic              line_valid,
    output logic              line_dirty,
    output logic [TAG_W-1:0]  line_tag,
    output logic [BLK_W-1:0]  line_blk,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [BLK_W-1:0]  fill_blk,
    input  logic              clr_dirty
);

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tags [SETS];
    logic [BLK_W-1:0] data [SETS];

    assign line_valid = valid[idx];
    assign line_dirty = dirty[idx];
    assign line_tag   = tags[idx];
    assign line_blk   = data[idx];
    assign hit        = line_valid && (line_tag == look_tag);
    assign rd_word    = line_blk[word*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty[idx] <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset; a write landing in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_en) begin
                tags[idx] <= fill_tag;
                data[idx] <= fill_blk;
            end else if (wr_en) begin
                data[idx][word*DATA_W +: DATA_W] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/cache_2way.sv
// Two-way set-associative write-back, write-allocate cache controller with
// true-LRU per set. Hits finish in the request cycle; misses write back then fetch.
//
//   state   | meaning
//   S_IDLE  | serve hits; on a miss pick and register the victim and block address
//   S_WB    | write the dirty victim block to memory until bus_done
//   S_FETCH | read the requested block into the victim until bus_done
module cache_2way
    import cache_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WORDS  = 2,
    parameter int SETS   = 2,
    parameter int ADDR_W = 6,
    localparam int WB    = log2c(WORDS),
    localparam int IB    = log2c(SETS),
    localparam int TAG_W = ADDR_W - IB - WB,
    localparam int BA_W  = ADDR_W - WB,
    localparam int BLK_W = DATA_W * WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pr_din,
    output logic [DATA_W-1:0] pr_dout,
    input  logic [ADDR_W-1:0] pr_addr,
    input  logic              pr_rd,
    input  logic              pr_wr,
    output logic              pr_done,
    input  logic [BLK_W-1:0]  bus_din,
    output logic [BLK_W-1:0]  bus_dout,
    input  logic              bus_done,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [BA_W-1:0]   bus_addr
);

    state_t           state, state_nx;
    logic             victim, victim_nx;
    logic [BA_W-1:0]  miss_ba, miss_ba_nx;
    logic [SETS-1:0]  lru, lru_nx;

    logic [WB-1:0]    pr_word;
    logic [IB-1:0]    pr_index;
    logic [TAG_W-1:0] pr_tag;
    logic [IB-1:0]    cur_index;
    logic             req, hit_way, vsel;

    logic [1:0]        hit, line_valid, line_dirty, wr_en, fill_en, clr_dirty;
    logic [DATA_W-1:0] rd_word  [2];
    logic [TAG_W-1:0]  line_tag [2];
    logic [BLK_W-1:0]  line_blk [2];

    assign pr_word  = WB'(addr_field(32'(pr_addr), 0, WB));
    assign pr_index = IB'(addr_field(32'(pr_addr), WB, IB));
    assign pr_tag   = TAG_W'(addr_field(32'(pr_addr), WB + IB, TAG_W));

    // During a miss the ways are addressed from the registered block address so the
    // bus side never depends combinationally on the processor inputs.
    assign cur_index = (state == S_IDLE) ? pr_index : miss_ba[IB-1:0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .DATA_W(DATA_W),
            .WORDS (WORDS),
            .SETS  (SETS),
            .TAG_W (TAG_W)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .idx       (cur_index),
            .word      (pr_word),
            .look_tag  (pr_tag),
            .hit       (hit[w]),
            .rd_word   (rd_word[w]),
            .line_valid(line_valid[w]),
            .line_dirty(line_dirty[w]),
            .line_tag  (line_tag[w]),
            .line_blk  (line_blk[w]),
            .wr_en     (wr_en[w]),
            .wr_data   (pr_din),
            .fill_en   (fill_en[w]),
            .fill_tag  (miss_ba[BA_W-1:IB]),
            .fill_blk  (bus_din),
            .clr_dirty (clr_dirty[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            victim  <= 1'b0;
            miss_ba <= '0;
            lru     <= '0;
        end else begin
            state   <= state_nx;
            victim  <= victim_nx;
            miss_ba <= miss_ba_nx;
            lru     <= lru_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        victim_nx  = victim;
        miss_ba_nx = miss_ba;
        lru_nx     = lru;
        pr_done    = 1'b0;
        pr_dout    = '0;
        wr_en      = '0;
        fill_en    = '0;
        clr_dirty  = '0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        bus_addr   = '0;
        bus_dout   = '0;
        req        = pr_rd | pr_wr;
        hit_way    = hit[1];
        vsel       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req && (|hit)) begin
                    pr_done            = 1'b1;
                    pr_dout            = rd_word[hit_way];
                    wr_en[hit_way]     = pr_wr;
                    lru_nx[cur_index]  = ~hit_way;
                end else if (req) begin
                    if (!line_valid[0])      vsel = 1'b0;
                    else if (!line_valid[1]) vsel = 1'b1;
                    else                     vsel = lru[cur_index];
                    victim_nx  = vsel;
                    miss_ba_nx = pr_addr[ADDR_W-1:WB];
                    state_nx   = (line_valid[vsel] && line_dirty[vsel]) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                bus_wr   = 1'b1;
                bus_addr = {line_tag[victim], cur_index};
                bus_dout = line_blk[victim];
                if (bus_done) begin
                    clr_dirty[victim] = 1'b1;
                    state_nx          = S_FETCH;
                end
            end
            S_FETCH: begin
                bus_rd   = 1'b1;
                bus_addr = miss_ba;
                if (bus_done) begin
                    fill_en[victim]   = 1'b1;
                    lru_nx[cur_index] = ~victim;
                    state_nx          = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_2way.sv
// Scoreboard bench for cache_2way: a recency-list cache model plus a flat shadow
// memory predict read data, bus transfers and latency; a memory responder plays the bus.
module tb_cache_2way;

    localparam int DATA_W = 8;
    localparam int WORDS  = 2;
    localparam int SETS   = 2;
    localparam int ADDR_W = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pr_din, pr_dout;
    logic [5:0]  pr_addr;
    logic        pr_rd, pr_wr, pr_done;
    logic [15:0] bus_din = 16'h0;
    logic [15:0] bus_dout;
    logic        bus_done = 1'b0;
    logic        bus_rd, bus_wr;
    logic [4:0]  bus_addr;

    cache_2way #(.DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .pr_din(pr_din), .pr_dout(pr_dout), .pr_addr(pr_addr),
        .pr_rd(pr_rd), .pr_wr(pr_wr), .pr_done(pr_done), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_done(bus_done), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_addr(bus_addr)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int ba; logic [15:0] data; } bus_exp_t;
    typedef struct { bit rd; logic [7:0] data; } pr_exp_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] bus_mem [64];
    logic [7:0] shadow  [64];
    bit         dirty_blk [32];
    int         recent [$];
    bus_exp_t   bus_q [$];
    pr_exp_t    pr_q [$];
    int         d_wb = 0;
    int         d_rd = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model one access; returns the expected cycles from request to pr_done.
    function automatic int predict(input logic [5:0] addr, input bit wr, input logic [7:0] din);
        int ba, set, pos, last_same, n_same, v, lat;
        bit wb;
        bus_exp_t be;
        pr_exp_t pe;
        ba = int'(addr) >> 1;
        set = ba & 1;
        pos = -1; last_same = -1; n_same = 0; wb = 0;
        for (int i = 0; i < recent.size(); i++) if (recent[i] == ba) pos = i;
        if (pos >= 0) begin
            recent.delete(pos);
            lat = 0;
        end else begin
            for (int i = 0; i < recent.size(); i++)
                if ((recent[i] & 1) == set) begin n_same++; last_same = i; end
            if (n_same == 2) begin
                v = recent[last_same];
                if (dirty_blk[v]) begin
                    be.wr = 1'b1; be.ba = v; be.data = {shadow[2*v+1], shadow[2*v]};
                    bus_q.push_back(be);
                    dirty_blk[v] = 1'b0;
                    wb = 1'b1;
                end
                recent.delete(last_same);
            end
            be.wr = 1'b0; be.ba = ba; be.data = 16'h0;
            bus_q.push_back(be);
            lat = wb ? 3 + d_wb + d_rd : 2 + d_rd;
        end
        recent.push_front(ba);
        pe.rd = !wr; pe.data = shadow[addr];
        pr_q.push_back(pe);
        if (wr) begin
            shadow[addr] = din;
            dirty_blk[ba] = 1'b1;
        end
        return lat;
    endfunction

    task automatic do_req(input logic [5:0] a, input bit wr, input logic [7:0] din,
                          input int dwb, input int drd);
        int exp_lat, n;
        d_wb = dwb;
        d_rd = drd;
        exp_lat = predict(a, wr, din);
        @(posedge clk); #1;
        pr_addr = a; pr_din = din; pr_wr = wr;
        pr_rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pr_done) break;
            n++;
            if (n > 300) begin
                errors++; checks++;
                $display("FAIL req_timeout: addr 0x%0h no pr_done after %0d cycles", a, n);
                break;
            end
        end
        check("latency", 32'(n), 32'(exp_lat));
        @(posedge clk); #1;
        pr_rd = 1'b0; pr_wr = 1'b0;
        pr_addr = 6'($urandom); pr_din = 8'($urandom);
    endtask

    // Processor-side monitor
    always @(negedge clk) begin
        pr_exp_t e;
        if (!reset && pr_done) begin
            if (pr_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL pr_unexpected: pr_done with no outstanding request at %0t", $time);
            end else begin
                e = pr_q.pop_front();
                if (e.rd) check("pr_dout", 32'(pr_dout), 32'(e.data));
            end
        end
    end

    // Memory responder and bus monitor
    bit          active = 1'b0;
    int          cnt = 0;
    bit          unstable = 1'b0;
    bit          cap_wr = 1'b0;
    logic [4:0]  cap_addr = 5'h0;
    logic [15:0] cap_dout = 16'h0;

    always @(negedge clk) begin
        bus_exp_t e;
        int a;
        if (bus_done) bus_done = 1'b0;
        if (reset) begin
            active = 1'b0;
            cnt = 0;
        end else if (bus_rd || bus_wr) begin
            if (!active) begin
                active = 1'b1; cnt = 0; unstable = 1'b0;
                cap_wr = bus_wr; cap_addr = bus_addr; cap_dout = bus_dout;
                if (bus_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL bus_unexpected: wr=%0d addr=0x%0h at %0t", bus_wr, bus_addr, $time);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_kind_wr", 32'(bus_wr), 32'(e.wr));
                    check("bus_addr", 32'(bus_addr), 32'(e.ba));
                    if (e.wr) check("bus_wb_data", 32'(bus_dout), 32'(e.data));
                end
            end else if (bus_addr !== cap_addr || bus_dout !== cap_dout || bus_wr !== cap_wr) begin
                unstable = 1'b1;
            end
            if ((bus_rd && bus_wr) || pr_done) unstable = 1'b1;
            if (cnt == (cap_wr ? d_wb : d_rd)) begin
                a = int'(cap_addr);
                if (cap_wr) begin
                    bus_mem[2*a]   = bus_dout[7:0];
                    bus_mem[2*a+1] = bus_dout[15:8];
                end else begin
                    bus_din = {bus_mem[2*a+1], bus_mem[2*a]};
                end
                bus_done = 1'b1;
                active = 1'b0;
                check("bus_stable", 32'(unstable), 32'd0);
            end else begin
                cnt++;
            end
        end else begin
            check("bus_idle_zero", {11'h0, bus_addr, bus_dout}, 32'h0);
        end
    end

    initial begin
        int n;
        bus_exp_t be;
        reset = 1'b1; pr_rd = 1'b0; pr_wr = 1'b0; pr_addr = 6'h0; pr_din = 8'h0;
        for (int i = 0; i < 64; i++) bus_mem[i] = 8'($urandom);
        bus_mem[0] = 8'hAA;
        bus_mem[1] = 8'hBB;
        for (int i = 0; i < 64; i++) shadow[i] = bus_mem[i];
        for (int i = 0; i < 32; i++) dirty_blk[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus_outputs", {9'h0, bus_rd, bus_wr, bus_addr, bus_dout}, 32'h0);
        check("reset_pr_done", 32'(pr_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Cold read, write hit, LRU clean replacement, dirty eviction, slow memory
        do_req(6'h00, 1'b0, 8'h00, 0, 0);
        do_req(6'h01, 1'b1, 8'h5C, 0, 0);
        do_req(6'h01, 1'b0, 8'h00, 0, 0);
        do_req(6'h04, 1'b0, 8'h00, 0, 1);
        do_req(6'h00, 1'b0, 8'h00, 0, 0);
        do_req(6'h08, 1'b0, 8'h00, 0, 2);
        do_req(6'h00, 1'b0, 8'h00, 0, 0);
        do_req(6'h04, 1'b1, 8'h77, 0, 0);
        do_req(6'h00, 1'b0, 8'h00, 0, 0);
        do_req(6'h08, 1'b0, 8'h00, 2, 1);
        do_req(6'h12, 1'b0, 8'h00, 0, 5);

        // Reset in the middle of a fetch to the empty way of set 1
        d_rd = 1000;
        be.wr = 1'b0; be.ba = 17; be.data = 16'h0;
        bus_q.push_back(be);
        @(posedge clk); #1;
        pr_addr = 6'h22; pr_rd = 1'b1;
        n = 0;
        while (!bus_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_fetch_bus_rd", 32'(bus_rd), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; pr_rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_fetch_reset_bus", {9'h0, bus_rd, bus_wr, bus_addr, bus_dout}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        recent.delete();
        for (int i = 0; i < 32; i++) dirty_blk[i] = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = bus_mem[i];
        do_req(6'h00, 1'b0, 8'h00, 0, 0);
        do_req(6'h22, 1'b0, 8'h00, 0, 1);

        // Randomized traffic, biased toward a few blocks to mix hits and evictions
        for (int k = 0; k < 300; k++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            do_req(a, 1'($urandom_range(0, 1)), 8'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("pr_queue_drained", 32'(pr_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_2way.md
# cache_2way

Parametrised two-way set-associative, write-back, write-allocate cache controller between the processor port and the word-addressed memory bus. Successor to the direct-mapped controller: configurable data width, words per block and set count, with true-LRU replacement per set and registered, non-tristated bus outputs. Hits complete combinationally in the request cycle. Misses run an optional write-back of the victim, then a block fetch.

## Interface
- `DATA_W`, 8: processor word width.
- `WORDS`, 2: words per block (power of 2, ≥2).
- `SETS`, 2: number of sets (power of 2, ≥2).
- `ADDR_W`, 6: processor word address width.
- Derived:
  - `WB = log2(WORDS)`, `IB = log2(SETS)`, `TAG_W = ADDR_W-IB-WB` (must be ≥1).
  - Address fields: word = `pr_addr[WB-1:0]`; index = `pr_addr[WB+IB-1:WB]`; tag = upper bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pr_din` in DATA_W: write data.
- `pr_dout` out DATA_W: read data.
- `pr_addr` in ADDR_W: request address.
- `pr_rd` in 1: read request.
- `pr_wr` in 1: write request.
- `pr_done` out 1: request complete this cycle.
- `bus_din` in DATA_W*WORDS: fetched block; word 0 in the LSBs.
- `bus_dout` out DATA_W*WORDS: write-back block.
- `bus_done` in 1: memory completes the current transfer.
- `bus_rd` out 1: block read.
- `bus_wr` out 1: block write.
- `bus_addr` out ADDR_W-WB: block address `{tag,index}`.

## Operation
- **Storage per way per set:** valid, dirty, tag, and WORDS data words. One LRU bit per set names the least-recently-used way.
- **States:** `S_IDLE`, `S_WB`, `S_FETCH`.
- **S_IDLE:**
  - `req = pr_rd|pr_wr`. Hit means a valid way with a matching tag; at most one way can match.
  - Write has priority if `pr_rd` and `pr_wr` are both high.
  - **Hit:**
    - `pr_done=1`; `pr_dout` is the addressed word.
    - On a write, the word is updated and dirty set at the clock edge.
    - LRU is set to the other way.
  - **Miss:**
    - Select the victim: the first invalid way (way 0 first), otherwise the LRU way. Register it.
    - Go to `S_WB` if the victim is valid and dirty; otherwise go to `S_FETCH`.
- **S_WB:**
  - `bus_wr=1`, `bus_addr={victim tag,index}`, `bus_dout`=victim block.
  - Held until `bus_done`; then clear the victim's dirty bit and go to `S_FETCH`.
- **S_FETCH:**
  - `bus_rd=1`, `bus_addr=pr_addr[ADDR_W-1:WB]`.
  - On `bus_done`: the victim takes `bus_din`, the tag, valid=1 and dirty=0; LRU is set to the other way; go to `S_IDLE`.
  - The retried request then hits.
- **Outside S_WB/S_FETCH:** `bus_rd`, `bus_wr`, `bus_addr` and `bus_dout` are 0. No Z on any output.
- **Ignored inputs:** `bus_done` in `S_IDLE` is ignored. A `req` without a hit is never acknowledged until the fill completes.
- **Processor hold rule:** the processor holds `pr_addr`, `pr_din`, `pr_rd` and `pr_wr` stable until `pr_done`. If the request drops mid-miss, the miss still completes and fills the line; no `pr_done` follows.

## Timing
- **Reset:**
  - State `S_IDLE`; all valid, dirty and LRU bits 0.
  - Bus outputs 0 from the cycle after `reset` is sampled high.
  - `pr_done`=0 after reset, since nothing is valid.
  - Data and tag arrays are not reset.
  - Reset mid-WB or mid-FETCH aborts the transfer with no fill.
- **Hit latency:** 0 cycles (`pr_done` in the request cycle).
- **Clean miss:**
  - Miss detected in cycle 0; `bus_rd` high from cycle 1.
  - `bus_done` sampled in cycle k; `pr_done` in cycle k+1.
- **Dirty miss:** adds the WB phase, and `bus_rd` rises the cycle after the WB `bus_done`.
- **Bus outputs:** registered, or decoded from registered state and victim only; no combinational path from `pr_*` to `bus_wr`/`bus_rd`.

## Structure
- Package `cache_pkg`:
  - state enum (`S_IDLE`, `S_WB`, `S_FETCH`);
  - `clog2`-based derived-width localparams/functions;
  - field-extract helpers.
- Sub-module `cache_way`: one way's valid/dirty/tag/data arrays, with lookup (hit, read word) and write/fill ports; instantiated twice.
- The top level holds the FSM, the LRU bits and the victim register.

## Test plan
Defaults (DATA_W=8, WORDS=2, SETS=2, ADDR_W=6).
1. **Cold read:** reset, then read 0x00 → `bus_rd`=1 with `bus_addr`=0x00 next cycle; return `bus_din`=0xBBAA with `bus_done` → `pr_done`=1 and `pr_dout`=0xAA the following cycle.
2. **Write hit:** write 0x01 with 0x5C → `pr_done` in the same cycle with no bus activity; a read of 0x01 then returns 0x5C at 0 latency.
3. **LRU clean replacement:** fill 0x00 and 0x04 (both set 0), read 0x00, then read 0x08 → no `bus_wr`; `bus_rd` with `bus_addr`=0x04 replaces the 0x04 line; a read of 0x00 still hits.
4. **Dirty eviction:** fill 0x00/0x04, write 0x04=0x77, read 0x00, read 0x08 →
   - `bus_wr` with `bus_addr`=0x02 and `bus_dout[7:0]`=0x77;
   - then `bus_rd` with `bus_addr`=0x04;
   - `pr_done` after the second `bus_done`.
5. **Slow memory:** hold `bus_done` low for 5 cycles in `S_FETCH` → `bus_rd` and `bus_addr` stay stable and `pr_done` stays 0 throughout.
6. **Reset mid-fetch:** assert `reset` while `bus_rd`=1 → next cycle all bus outputs are 0; a re-read of 0x00 misses again.
